// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - fetch-stage bus bundle between ROM, fetch unit and decoder
//
// Purpose : groups the ROM address/data pair and the decode-side signals of the
//           fetch stage so that they travel as one port.
// Signals : InstAddress    ROM address (registered PC)
//           InstIn         ROM data, combinational from InstAddress
//           Stall          downstream cannot accept; hold PC and IR
//           Redirect       taken control transfer
//           RedirectTarget new PC when Redirect is high
//           Inst           instruction register to decode
//           InstPC         address Inst was fetched from
//           InstValid      Inst is a real, non-squashed instruction
//           Halted         sticky fetch-stopped flag
// Modports: master - the fetch unit; slave - the ROM/decoder/execute environment.

interface inst_fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int INST_W = 10
);
   logic [ADDR_W-1:0] InstAddress;
   logic [INST_W-1:0] InstIn;
   logic              Stall;
   logic              Redirect;
   logic [ADDR_W-1:0] RedirectTarget;
   logic [INST_W-1:0] Inst;
   logic [ADDR_W-1:0] InstPC;
   logic              InstValid;
   logic              Halted;

   modport master (
      output InstAddress,
      input  InstIn,
      input  Stall,
      input  Redirect,
      input  RedirectTarget,
      output Inst,
      output InstPC,
      output InstValid,
      output Halted
   );

   modport slave (
      input  InstAddress,
      output InstIn,
      output Stall,
      output Redirect,
      output RedirectTarget,
      input  Inst,
      input  InstPC,
      input  InstValid,
      input  Halted
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - program counter, instruction register and halt-drain for the ROM fetch stage
//
// Purpose : owns the PC that addresses the instruction ROM, captures the ROM word
//           into an instruction register for decode, and handles stall, redirect
//           and the halt-drain sequence.
// Ports   : i_clk  clock, rising edge
//           i_rst  asynchronous, active-high reset
//           bus    inst_fetch_unit_if.master (ROM address/data, stall, redirect,
//                  instruction register outputs, halted flag)

module inst_fetch_unit #(
   parameter int                 ADDR_W       = 16,
   parameter int                 INST_W       = 10,
   parameter logic [ADDR_W-1:0]  RESET_PC     = 16'h0000,
   parameter logic [INST_W-1:0]  HALT_INST    = 10'b1110000000,
   parameter int                 DRAIN_CYCLES = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   inst_fetch_unit_if.master  bus
);

   localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);

   localparam logic [1:0] S_RUN    = 2'b00;
   localparam logic [1:0] S_DRAIN  = 2'b01;
   localparam logic [1:0] S_HALTED = 2'b10;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_pc;
   logic [INST_W-1:0] r_inst;
   logic [ADDR_W-1:0] r_inst_pc;
   logic              r_inst_valid;
   logic              r_halted;

   logic [1:0]        w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [INST_W-1:0] w_inst_nxt;
   logic [ADDR_W-1:0] w_inst_pc_nxt;
   logic              w_inst_valid_nxt;
   logic              w_halted_nxt;
   logic              w_is_halt;

   assign w_is_halt = (bus.InstIn == HALT_INST);

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_pc_nxt         = r_pc;
      w_inst_nxt       = r_inst;
      w_inst_pc_nxt    = r_inst_pc;
      w_inst_valid_nxt = r_inst_valid;
      w_halted_nxt     = r_halted;

      case (r_state)
         S_RUN: begin
            if (bus.Redirect) begin
               // The word currently in the IR is wrong-path; squash it but keep
               // its contents so decode sees stable data while invalid.
               w_pc_nxt         = bus.RedirectTarget;
               w_inst_valid_nxt = 1'b0;
            end else if (!bus.Stall) begin
               w_inst_nxt       = bus.InstIn;
               w_inst_pc_nxt    = r_pc;
               w_inst_valid_nxt = 1'b1;
               if (w_is_halt) begin
                  // Do not fetch past the halt; the PC stays on it while draining.
                  w_state_nxt = S_DRAIN;
                  w_cnt_nxt   = CNT_LOAD;
               end else begin
                  w_pc_nxt = r_pc + ADDR_W'(1);
               end
            end
         end

         S_DRAIN: begin
            if (bus.Redirect) begin
               // A redirect resolved behind the halt means the halt itself was
               // wrong-path, so normal fetching resumes at the target.
               w_pc_nxt         = bus.RedirectTarget;
               w_inst_valid_nxt = 1'b0;
               w_state_nxt      = S_RUN;
            end else if (!bus.Stall) begin
               w_inst_valid_nxt = 1'b0;
               w_cnt_nxt        = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  w_state_nxt  = S_HALTED;
                  w_halted_nxt = 1'b1;
               end
            end
         end

         S_HALTED: begin
            w_inst_valid_nxt = 1'b0;
            w_halted_nxt     = 1'b1;
         end

         default: begin
            // Unreachable encoding: stop fetching rather than run from an unknown PC.
            w_state_nxt      = S_HALTED;
            w_inst_valid_nxt = 1'b0;
            w_halted_nxt     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_RUN;
         r_cnt        <= CNT_LOAD;
         r_pc         <= RESET_PC;
         r_inst       <= '0;
         r_inst_pc    <= '0;
         r_inst_valid <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_pc         <= w_pc_nxt;
         r_inst       <= w_inst_nxt;
         r_inst_pc    <= w_inst_pc_nxt;
         r_inst_valid <= w_inst_valid_nxt;
         r_halted     <= w_halted_nxt;
      end
   end

   assign bus.InstAddress = r_pc;
   assign bus.Inst        = r_inst;
   assign bus.InstPC      = r_inst_pc;
   assign bus.InstValid   = r_inst_valid;
   assign bus.Halted      = r_halted;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard testbench for inst_fetch_unit

module tb_inst_fetch_unit;

   localparam logic [9:0] HALT = 10'b1110000000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   inst_fetch_unit_if #(.ADDR_W(16), .INST_W(10)) ifa ();
   inst_fetch_unit_if #(.ADDR_W(16), .INST_W(10)) ifb ();

   logic [9:0] rom [0:63];

   assign ifa.InstIn = rom[ifa.InstAddress[5:0]];
   assign ifb.InstIn = {1'b0, ifb.InstAddress[8:0]};
   assign ifb.Stall          = 1'b0;
   assign ifb.Redirect       = 1'b0;
   assign ifb.RedirectTarget = 16'h0000;

   inst_fetch_unit #(.RESET_PC(16'h0000)) u_dut_a (
      .i_clk (clk),
      .i_rst (rst_a),
      .bus   (ifa.master)
   );

   inst_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut_b (
      .i_clk (clk),
      .i_rst (rst_b),
      .bus   (ifb.master)
   );

   typedef struct {
      logic [9:0]  inst;
      logic [15:0] pc;
   } fetch_t;

   fetch_t     sb [$];
   fetch_t     exp_item;
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [15:0] exp_pc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic st, input logic rd, input logic [15:0] tgt);
      ifa.Stall          = st;
      ifa.Redirect       = rd;
      ifa.RedirectTarget = tgt;
   endtask

   task automatic step(input logic st, input logic rd, input logic [15:0] tgt);
      drive(st, rd, tgt);
      @(posedge clk);
      #1;
   endtask

   // One unstalled RUN cycle: push the expected capture, clock, pop and compare.
   task automatic fetch_step();
      check("addr_pre", ifa.InstAddress, exp_pc);
      sb.push_back('{rom[exp_pc[5:0]], exp_pc});
      step(1'b0, 1'b0, 16'h0000);
      if (rom[exp_pc[5:0]] != HALT) exp_pc = exp_pc + 16'd1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         exp_item = sb.pop_front();
         check("inst",      ifa.Inst,      exp_item.inst);
         check("inst_pc",   ifa.InstPC,    exp_item.pc);
         check("valid",     ifa.InstValid, 1'b1);
         check("addr_post", ifa.InstAddress, exp_pc);
      end
   endtask

   task automatic check_reset_a();
      check("rst_addr",   ifa.InstAddress, 16'h0000);
      check("rst_inst",   ifa.Inst,        10'h000);
      check("rst_ipc",    ifa.InstPC,      16'h0000);
      check("rst_valid",  ifa.InstValid,   1'b0);
      check("rst_halted", ifa.Halted,      1'b0);
   endtask

   // Called mid-cycle; reset is applied and released well away from any edge.
   task automatic do_reset();
      rst_a = 1'b1;
      #2;
      check_reset_a();
      rst_a  = 1'b0;
      exp_pc = 16'h0000;
      sb.delete();
      drive(1'b0, 1'b0, 16'h0000);
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      drive(1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 64; i++) rom[i] = {1'b0, 9'(i * 7 + 1)};

      // Reset held across an edge must keep reset values.
      #2;
      check_reset_a();
      @(posedge clk);
      #1;
      check_reset_a();
      do_reset();

      // 1: free run, then 2: stall at PC 5
      for (int i = 0; i < 5; i++) fetch_step();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 16'h0000);
         check("stall_addr",  ifa.InstAddress, 16'd5);
         check("stall_inst",  ifa.Inst,        rom[4]);
         check("stall_ipc",   ifa.InstPC,      16'd4);
         check("stall_valid", ifa.InstValid,   1'b1);
      end
      for (int i = 0; i < 4; i++) fetch_step();

      // 3: redirect with simultaneous stall at PC 9
      check("pre_redir_addr", ifa.InstAddress, 16'd9);
      step(1'b1, 1'b1, 16'd4);
      check("redir_addr",  ifa.InstAddress, 16'd4);
      check("redir_valid", ifa.InstValid,   1'b0);
      check("redir_inst",  ifa.Inst,        rom[8]);
      check("redir_ipc",   ifa.InstPC,      16'd8);
      exp_pc = 16'd4;
      fetch_step();

      // 4: halt at ROM[3], stall once while draining, then halt
      do_reset();
      rom[3] = HALT;
      for (int i = 0; i < 4; i++) fetch_step();
      check("halt_hold_addr", ifa.InstAddress, 16'd3);
      check("halt_no_halted", ifa.Halted,      1'b0);
      step(1'b1, 1'b0, 16'h0000);
      check("drain_stall_valid",  ifa.InstValid, 1'b1);
      check("drain_stall_inst",   ifa.Inst,      HALT);
      check("drain_stall_halted", ifa.Halted,    1'b0);
      step(1'b0, 1'b0, 16'h0000);
      check("drain1_valid",  ifa.InstValid,   1'b0);
      check("drain1_halted", ifa.Halted,      1'b0);
      check("drain1_addr",   ifa.InstAddress, 16'd3);
      step(1'b0, 1'b0, 16'h0000);
      check("halted",        ifa.Halted,      1'b1);
      check("halted_valid",  ifa.InstValid,   1'b0);
      step(1'b0, 1'b1, 16'd7);
      check("halted_redir_addr", ifa.InstAddress, 16'd3);
      check("halted_redir_flag", ifa.Halted,      1'b1);
      check("halted_redir_vld",  ifa.InstValid,   1'b0);
      step(1'b1, 1'b0, 16'h0000);
      check("halted_stall_flag", ifa.Halted,      1'b1);

      // 5: redirect on the first drain cycle cancels the halt
      do_reset();
      for (int i = 0; i < 4; i++) fetch_step();
      step(1'b0, 1'b1, 16'd8);
      check("drain_redir_addr",   ifa.InstAddress, 16'd8);
      check("drain_redir_valid",  ifa.InstValid,   1'b0);
      check("drain_redir_halted", ifa.Halted,      1'b0);
      exp_pc = 16'd8;
      fetch_step();
      fetch_step();
      check("resumed_halted", ifa.Halted, 1'b0);

      // 7: asynchronous reset mid-cycle
      #3;
      rst_a = 1'b1;
      #1;
      check_reset_a();
      #1;
      rst_a = 1'b0;
      @(posedge clk);
      #1;

      // 6: RESET_PC = FFFF wraps to 0
      check("b_rst_addr",  ifb.InstAddress, 16'hFFFF);
      check("b_rst_valid", ifb.InstValid,   1'b0);
      rst_b = 1'b0;
      @(posedge clk);
      #1;
      check("b_wrap_addr",  ifb.InstAddress, 16'h0000);
      check("b_wrap_ipc",   ifb.InstPC,      16'hFFFF);
      check("b_wrap_inst",  ifb.Inst,        10'h1FF);
      check("b_wrap_valid", ifb.InstValid,   1'b1);
      @(posedge clk);
      #1;
      check("b_next_addr",  ifb.InstAddress, 16'h0001);
      check("b_next_ipc",   ifb.InstPC,      16'h0000);
      check("b_next_inst",  ifb.Inst,        10'h000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
